// File: rtl/iob_eth_axi_ram_pkg.sv
// +----------------------------------------------------------------------+
// | iob_eth_axi_ram_pkg : FSM encodings and AXI response codes            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package iob_eth_axi_ram_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic [0:0] {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } rstate_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

`default_nettype wire

// File: rtl/iob_eth_axi_ram_dp.sv
// +----------------------------------------------------------------------+
// | iob_eth_axi_ram_dp : simple dual-port RAM, byte-write port and        |
// | registered read port with enable.  Rev 1.0                            |
// +----------------------------------------------------------------------+
`default_nettype none

module iob_eth_axi_ram_dp #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_cke,
  input  logic                  i_rst,
  input  logic [DATA_W/8-1:0]   i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int NUM_BYTES = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Array is deliberately unreset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_cke) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (i_we[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)               r_rdata <= '0;
    else if (i_cke && i_re)  r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/iob_eth_axi_ram.sv
// +----------------------------------------------------------------------+
// | iob_eth_axi_ram : AXI4 INCR burst slave memory, independent R/W FSMs  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module iob_eth_axi_ram
  import iob_eth_axi_ram_pkg::*;
#(
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int MEM_ADDR_W = 12
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    arst_i,
  input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,
  input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
  input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
  input  logic                    axi_wlast_i,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  output logic [1:0]              axi_bresp_o,
  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i,
  input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
  input  logic                    axi_arvalid_i,
  output logic                    axi_arready_o,
  output logic [AXI_DATA_W-1:0]   axi_rdata_o,
  output logic [1:0]              axi_rresp_o,
  output logic                    axi_rlast_o,
  output logic                    axi_rvalid_o,
  input  logic                    axi_rready_i
);

  localparam logic [MEM_ADDR_W-1:0] c_addr_one = MEM_ADDR_W'(1);
  localparam logic [AXI_LEN_W:0]    c_beat_one = (AXI_LEN_W+1)'(1);

  wstate_t                 r_wstate;
  logic [MEM_ADDR_W-1:0]   r_waddr;
  logic [AXI_LEN_W:0]      r_wbeats;
  logic                    r_werr, r_awready, r_wready, r_bvalid;
  logic [1:0]              r_bresp;

  rstate_t                 r_rstate;
  logic [MEM_ADDR_W-1:0]   r_raddr;
  logic [AXI_LEN_W:0]      r_rbeats;
  logic                    r_arready, r_rvalid, r_rlast;

  logic                    w_wfire, w_wfinal, w_wbad, w_rissue;
  logic [AXI_DATA_W/8-1:0] w_we;
  logic                    w_unused_addr;

  assign w_wfire  = axi_wvalid_i && r_wready;
  assign w_wfinal = (r_wbeats == c_beat_one);
  assign w_wbad   = (w_wfinal != axi_wlast_i);
  assign w_we     = w_wfire ? axi_wstrb_i : '0;
  assign w_rissue = (r_rstate == R_BURST) && (r_rbeats != '0) && (!r_rvalid || axi_rready_i);
  assign w_unused_addr = ^{axi_awaddr_i, axi_araddr_i};

  // Beat count alone ends the burst; wlast only feeds the error flag.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_wstate  <= W_IDLE;
      r_waddr   <= '0;
      r_wbeats  <= '0;
      r_werr    <= 1'b0;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
    end else if (cke_i) begin
      case (r_wstate)
        W_IDLE: if (axi_awvalid_i && r_awready) begin
          r_waddr   <= axi_awaddr_i[MEM_ADDR_W+1:2];
          r_wbeats  <= {1'b0, axi_awlen_i} + c_beat_one;
          r_werr    <= 1'b0;
          r_awready <= 1'b0;
          r_wready  <= 1'b1;
          r_wstate  <= W_DATA;
        end
        W_DATA: if (w_wfire) begin
          r_waddr  <= r_waddr + c_addr_one;
          r_wbeats <= r_wbeats - c_beat_one;
          if (w_wbad) r_werr <= 1'b1;
          if (w_wfinal) begin
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
            r_bresp  <= (r_werr || w_wbad) ? SLVERR : OKAY;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: if (axi_bready_i) begin
          r_bvalid  <= 1'b0;
          r_bresp   <= OKAY;
          r_awready <= 1'b1;
          r_wstate  <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_rstate  <= R_IDLE;
      r_raddr   <= '0;
      r_rbeats  <= '0;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
    end else if (cke_i) begin
      case (r_rstate)
        R_IDLE: if (axi_arvalid_i && r_arready) begin
          r_raddr   <= axi_araddr_i[MEM_ADDR_W+1:2];
          r_rbeats  <= {1'b0, axi_arlen_i} + c_beat_one;
          r_arready <= 1'b0;
          r_rstate  <= R_BURST;
        end
        R_BURST: begin
          if (w_rissue) begin
            r_raddr  <= r_raddr + c_addr_one;
            r_rbeats <= r_rbeats - c_beat_one;
            r_rvalid <= 1'b1;
            r_rlast  <= (r_rbeats == c_beat_one);
          end else if (r_rvalid && axi_rready_i) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            if (r_rlast) begin
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  iob_eth_axi_ram_dp #(
    .ADDR_W (MEM_ADDR_W),
    .DATA_W (AXI_DATA_W)
  ) u_dp (
    .i_clk   (clk_i),
    .i_cke   (cke_i),
    .i_rst   (arst_i),
    .i_we    (w_we),
    .i_waddr (r_waddr),
    .i_wdata (axi_wdata_i),
    .i_re    (w_rissue),
    .i_raddr (r_raddr),
    .o_rdata (axi_rdata_o)
  );

  assign axi_awready_o = r_awready;
  assign axi_wready_o  = r_wready;
  assign axi_bvalid_o  = r_bvalid;
  assign axi_bresp_o   = r_bresp;
  assign axi_arready_o = r_arready;
  assign axi_rvalid_o  = r_rvalid;
  assign axi_rlast_o   = r_rlast;
  assign axi_rresp_o   = OKAY;

endmodule

`default_nettype wire

// File: tb/tb_iob_eth_axi_ram.sv
// +----------------------------------------------------------------------+
// | tb_iob_eth_axi_ram : directed self-checking bench, 16-word memory     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_iob_eth_axi_ram;

  localparam int MEM_W = 4;
  localparam int DEPTH = 1 << MEM_W;

  logic        clk = 1'b0, cke = 1'b1, arst = 1'b0;
  logic [23:0] awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rlast, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] mdl    [DEPTH];
  logic [31:0] wbuf   [16];
  logic [31:0] rd_buf [16];

  always #5 clk = ~clk;

  iob_eth_axi_ram #(
    .AXI_ADDR_W (24),
    .AXI_DATA_W (32),
    .AXI_LEN_W  (8),
    .MEM_ADDR_W (MEM_W)
  ) dut (
    .clk_i (clk), .cke_i (cke), .arst_i (arst),
    .axi_awaddr_i (awaddr), .axi_awlen_i (awlen), .axi_awvalid_i (awvalid), .axi_awready_o (awready),
    .axi_wdata_i (wdata), .axi_wstrb_i (wstrb), .axi_wlast_i (wlast), .axi_wvalid_i (wvalid), .axi_wready_o (wready),
    .axi_bresp_o (bresp), .axi_bvalid_o (bvalid), .axi_bready_i (bready),
    .axi_araddr_i (araddr), .axi_arlen_i (arlen), .axi_arvalid_i (arvalid), .axi_arready_o (arready),
    .axi_rdata_o (rdata), .axi_rresp_o (rresp), .axi_rlast_o (rlast), .axi_rvalid_o (rvalid), .axi_rready_i (rready)
  );

  task automatic do_write(input logic [23:0] addr, input int len, input int last_at,
                          input logic [3:0] strb, input logic [1:0] exp_resp);
    int n = 0;
    int w;
    @(negedge clk);
    awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    n_assert++;
    if (n >= 50) begin n_fail++; $display("FAIL aw_timeout: awready=%b required 1", awready); end
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = wbuf[i]; wstrb = strb; wlast = (i == last_at); wvalid = 1'b1;
      n_assert++;
      if (wready !== 1'b1) begin n_fail++; $display("FAIL wready beat %0d: got %b required 1", i, wready); end
      w = (int'(addr[MEM_W+1:2]) + i) % DEPTH;
      for (int b = 0; b < 4; b++) if (strb[b]) mdl[w][b*8 +: 8] = wbuf[i][b*8 +: 8];
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    n_assert++;
    if (bvalid !== 1'b1 || bresp !== exp_resp) begin
      n_fail++; $display("FAIL bresp: got bvalid=%b bresp=%b required 1/%b", bvalid, bresp, exp_resp);
    end
    @(negedge clk);
    n_assert++;
    if (bvalid !== 1'b1 || bresp !== exp_resp) begin
      n_fail++; $display("FAIL bresp_hold: got bvalid=%b bresp=%b required 1/%b", bvalid, bresp, exp_resp);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    n_assert++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      n_fail++; $display("FAIL b_done: got bvalid=%b awready=%b required 0/1", bvalid, awready);
    end
  endtask

  task automatic do_read(input logic [23:0] addr, input int len, input bit toggle);
    int n = 0;
    int k = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [31:0] sdata = '0;
    logic slast = 1'b0;
    logic [31:0] exp;
    rready = 1'b0;
    @(negedge clk);
    araddr = addr; arlen = 8'(len); arvalid = 1'b1;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    n_assert++;
    if (n >= 50) begin n_fail++; $display("FAIL ar_timeout: arready=%b required 1", arready); end
    @(negedge clk);
    arvalid = 1'b0;
    n_assert++;
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL r_latency_early: rvalid=%b required 0", rvalid); end
    @(negedge clk);
    n_assert++;
    if (rvalid !== 1'b1) begin n_fail++; $display("FAIL r_latency: rvalid=%b required 1", rvalid); end
    while (k <= len && cyc < 200) begin
      if (stalled) begin
        n_assert++;
        if (rvalid !== 1'b1 || rdata !== sdata || rlast !== slast) begin
          n_fail++; $display("FAIL r_stall_hold: got %b/%h/%b required 1/%h/%b", rvalid, rdata, rlast, sdata, slast);
        end
      end
      rready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rvalid && rready) begin
        exp = mdl[(int'(addr[MEM_W+1:2]) + k) % DEPTH];
        n_assert++;
        if (rdata !== exp || rlast !== (k == len) || rresp !== 2'b00) begin
          n_fail++; $display("FAIL r_beat %0d: got %h last=%b resp=%b required %h last=%b resp=00",
                             k, rdata, rlast, rresp, exp, (k == len));
        end
        rd_buf[k] = rdata;
        k++;
        stalled = 1'b0;
      end else if (rvalid) begin
        stalled = 1'b1; sdata = rdata; slast = rlast;
      end else begin
        stalled = 1'b0;
        if (!toggle) begin
          n_assert++; n_fail++; $display("FAIL r_throughput beat %0d: rvalid=0 required 1", k);
        end
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    n_assert++;
    if (k <= len || arready !== 1'b1 || rvalid !== 1'b0) begin
      n_fail++; $display("FAIL r_done: beats=%0d arready=%b rvalid=%b required %0d/1/0", k, arready, rvalid, len + 1);
    end
  endtask

  task automatic test_reset();
    #1 arst = 1'b1;
    @(negedge clk);
    n_assert++;
    if (awready !== 1'b1 || arready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0 || bresp !== 2'b00) begin
      n_fail++; $display("FAIL reset_w: awready=%b arready=%b wready=%b bvalid=%b bresp=%b required 1 1 0 0 00",
                         awready, arready, wready, bvalid, bresp);
    end
    n_assert++;
    if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== 32'h0 || rresp !== 2'b00) begin
      n_fail++; $display("FAIL reset_r: rvalid=%b rlast=%b rdata=%h rresp=%b required 0 0 0 00", rvalid, rlast, rdata, rresp);
    end
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic test_burst4();
    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    do_write(24'h100, 3, 3, 4'hF, 2'b00);
    do_read(24'h100, 3, 1'b0);
    n_assert++;
    if (rd_buf[0] !== 32'h11 || rd_buf[3] !== 32'h44) begin
      n_fail++; $display("FAIL burst4_data: got %h..%h required 00000011..00000044", rd_buf[0], rd_buf[3]);
    end
  endtask

  task automatic test_fill_toggle();
    for (int i = 0; i < 16; i++) wbuf[i] = 32'hA500_0000 + 32'(i);
    do_write(24'h000, 15, 15, 4'hF, 2'b00);
    do_read(24'h020, 15, 1'b1);
    n_assert++;
    if (rd_buf[0] !== 32'hA500_0008 || rd_buf[15] !== 32'hA500_0007) begin
      n_fail++; $display("FAIL toggle_wrap: got %h..%h required a5000008..a5000007", rd_buf[0], rd_buf[15]);
    end
  endtask

  task automatic test_strobe();
    wbuf[0] = 32'hFFFF_FFFF;
    do_write(24'h014, 0, 0, 4'hF, 2'b00);
    wbuf[0] = 32'hAABB_CCDD;
    do_write(24'h014, 0, 0, 4'b0101, 2'b00);
    do_read(24'h014, 0, 1'b0);
    n_assert++;
    if (rd_buf[0] !== 32'hFFBB_FFDD) begin
      n_fail++; $display("FAIL strobe: got %h required ffbbffdd", rd_buf[0]);
    end
  endtask

  task automatic test_wlast_err();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hE0 + 32'(i);
    do_write(24'h028, 3, 1, 4'hF, 2'b10);
    do_read(24'h028, 3, 1'b0);
    n_assert++;
    if (rd_buf[3] !== 32'hE3) begin n_fail++; $display("FAIL wlast_len: got %h required 000000e3", rd_buf[3]); end
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hF0 + 32'(i);
    do_write(24'h028, 3, 3, 4'hF, 2'b00);
  endtask

  task automatic test_alias();
    wbuf[0] = 32'h1111_AAAA; wbuf[1] = 32'h2222_BBBB;
    do_write(24'h03C, 1, 1, 4'hF, 2'b00);
    do_read(24'h040, 0, 1'b0);
    n_assert++;
    if (rd_buf[0] !== 32'h2222_BBBB) begin n_fail++; $display("FAIL alias: got %h required 2222bbbb", rd_buf[0]); end
    do_read(24'h03C, 1, 1'b0);
  endtask

  task automatic test_cke();
    @(negedge clk);
    cke = 1'b0; awaddr = 24'h010; awlen = 8'd0; awvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_assert++;
      if (awready !== 1'b1 || wready !== 1'b0) begin
        n_fail++; $display("FAIL cke_freeze: awready=%b wready=%b required 1/0", awready, wready);
      end
    end
    cke = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    n_assert++;
    if (wready !== 1'b1) begin n_fail++; $display("FAIL cke_resume: wready=%b required 1", wready); end
    wdata = 32'h0BAD_CAFE; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    mdl[4] = 32'h0BAD_CAFE;
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    n_assert++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      n_fail++; $display("FAIL cke_bresp: bvalid=%b bresp=%b required 1/00", bvalid, bresp);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic test_reset_midburst();
    int n = 0;
    @(negedge clk);
    araddr = 24'h000; arlen = 8'd7; arvalid = 1'b1; rready = 1'b1;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    repeat (3) @(negedge clk);
    arst = 1'b1;
    #1;
    n_assert++;
    if (rvalid !== 1'b0 || arready !== 1'b1 || rlast !== 1'b0) begin
      n_fail++; $display("FAIL midburst_reset: rvalid=%b arready=%b rlast=%b required 0/1/0", rvalid, arready, rlast);
    end
    @(negedge clk);
    arst = 1'b0; rready = 1'b0;
    do_read(24'h000, 7, 1'b0);
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0 + 32'(i);
    fork
      do_write(24'h020, 3, 3, 4'hF, 2'b00);
      do_read(24'h000, 3, 1'b1);
    join
    do_read(24'h020, 3, 1'b0);
  endtask

  initial begin
    test_reset();
    test_burst4();
    test_fill_toggle();
    test_strobe();
    test_wlast_err();
    test_alias();
    test_cke();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
